iram_dp: RTL and testbench
==========================

// Module: iram_dp
// PURPOSE
//  Parametrised instruction RAM: one write (load) port with valid/ready handshake, one
//  synchronous read (fetch) port with 1-cycle latency and valid/error flags. Optional
//  post-reset clear sweep zeroes every word before the block accepts traffic.
//  Sits between the program loader (write side) and the processor fetch stage (read side).
// PARAMETERS
//  DATA_W          16  instruction word width in bits
//  ADDR_W          9   address bus width in bits (may exceed log2(DEPTH))
//  DEPTH           32  number of words implemented; legal addresses 0..DEPTH-1
//  CLEAR_ON_RESET  1   1: run zeroing sweep after reset; 0: go straight to READY
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       asynchronous, active-high reset
//  ld_valid  in   1       load request valid
//  ld_ready  out  1       load port can accept (high only in READY)
//  ld_addr   in   ADDR_W  load word address
//  ld_data   in   DATA_W  load word data
//  ld_err    out  1       1-cycle pulse: accepted load had out-of-range address
//  rd_en     in   1       fetch request
//  rd_addr   in   ADDR_W  fetch word address
//  rd_data   out  DATA_W  fetched word, registered
//  rd_valid  out  1       1-cycle pulse: rd_data updated by a fetch
//  rd_err    out  1       qualifies rd_valid: fetch address was out of range
//  busy      out  1       clear sweep in progress
// BEHAVIOUR
//  - Reset (async): rd_data=0, rd_valid=0, rd_err=0, ld_err=0, clear counter=0;
//    state=CLEAR if CLEAR_ON_RESET else READY. Memory array itself is not reset.
//  - States: CLEAR, READY. busy = (state==CLEAR); ld_ready = (state==READY), combinational.
//  - CLEAR: each clk edge writes mem[cnt]=0, cnt++; at cnt==DEPTH-1 write then -> READY.
//    busy falls after exactly DEPTH edges. rd_en and ld_valid ignored (no rd_valid, no write).
//  - rst asserted mid-sweep: sweep restarts from address 0 after release.
//  - READY is terminal until next reset.
//  - Load: write occurs on edge where ld_valid && ld_ready. If ld_addr<DEPTH,
//    mem[ld_addr]<=ld_data; else write dropped and ld_err=1 for the following cycle.
//  - Fetch: on edge with rd_en in READY, next cycle rd_valid=1 and
//    rd_data=mem[rd_addr] if rd_addr<DEPTH, rd_err=0; else rd_data=0, rd_err=1.
//  - rd_en low: rd_valid=0, rd_err=0, rd_data holds last value.
//  - Same-edge load and fetch to same in-range address: write-first, rd_data=ld_data.
//    Different addresses: both complete independently in that cycle.
//  - Address compare uses full ADDR_W; upper bits never aliased/truncated into range.
//  - Back-to-back fetches every cycle supported; throughput 1 word/cycle per port.
// TESTING
//  1 Reset, CLEAR_ON_RESET=1, DEPTH=32 -> busy high exactly 32 cycles, ld_ready low then high;
//    subsequent fetch of addr 0..31 returns 0 with rd_valid each.
//  2 Load addr 2=1025, addr 5=3075, then fetch 5,2 back-to-back -> rd_data 3075 then 1025,
//    rd_valid high two consecutive cycles, rd_err=0.
//  3 Load addr 40 (>=DEPTH) data 7 -> ld_err pulse 1 cycle, no array word changes;
//    fetch addr 40 -> rd_valid=1, rd_err=1, rd_data=0.
//  4 Same cycle load addr 3=2050 and fetch addr 3 -> next cycle rd_data=2050 (write-first).
//  5 Assert rst at sweep count 10, release -> busy lasts full 32 cycles again; fetch/load
//    requested during sweep produce no rd_valid and no write.
//  6 CLEAR_ON_RESET=0 -> busy=0 and ld_ready=1 on first edge after reset release.

Source files
------------

// File: rtl/iram_dp.sv
// Instruction RAM: handshaked load port, 1-cycle registered fetch port, and an
// optional post-reset zeroing sweep that holds both ports off until it finishes.
module iram_dp #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned DEPTH          = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              ld_err_q, ld_err_d;

  logic              isReady;
  logic              ldFire;
  logic              rdFire;
  logic              ldInRange;
  logic              rdInRange;
  logic              wrHit;
  logic [IDX_W-1:0]  ldIdx;
  logic [IDX_W-1:0]  rdIdx;

  // Range checks use the whole address so upper bits can never alias into the array.
  assign ldInRange = (32'(ld_addr) < DEPTH);
  assign rdInRange = (32'(rd_addr) < DEPTH);
  assign ldIdx     = ld_addr[IDX_W-1:0];
  assign rdIdx     = rd_addr[IDX_W-1:0];

  assign isReady  = (state_q == READY);
  assign ldFire   = ld_valid && isReady;
  assign rdFire   = rd_en && isReady;
  assign wrHit    = ldFire && ldInRange && (ld_addr == rd_addr);

  assign ld_ready = isReady;
  assign busy     = (state_q == CLEAR);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign ld_err   = ld_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rdFire;
    rd_err_d   = rdFire && !rdInRange;
    ld_err_d   = ldFire && !ldInRange;

    if (state_q == CLEAR) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = READY;
        cnt_d   = '0;
      end
    end

    // Write-first on a same-address collision: forward the load data.
    if (rdFire) begin
      if (!rdInRange) begin
        rd_data_d = '0;
      end else if (wrHit) begin
        rd_data_d = ld_data;
      end else begin
        rd_data_d = mem[rdIdx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      ld_err_q   <= ld_err_d;
    end
  end

  // The array has no reset; the sweep is the only way it gets zeroed.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (ldFire && ldInRange) begin
      mem[ldIdx] <= ld_data;
    end
  end

endmodule

// File: tb/tb_iram_dp.sv
// Directed bench for iram_dp: clear sweep, load/fetch, range errors, collisions,
// mid-sweep reset, and the no-clear variant.
module tb_iram_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [8:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_err;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        busy;

  logic        ncRst;
  logic        ncLdValid;
  logic        ncLdReady;
  logic [8:0]  ncLdAddr;
  logic [15:0] ncLdData;
  logic        ncLdErr;
  logic        ncRdEn;
  logic [8:0]  ncRdAddr;
  logic [15:0] ncRdData;
  logic        ncRdValid;
  logic        ncRdErr;
  logic        ncBusy;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  iram_dp #(.DATA_W(16), .ADDR_W(9), .DEPTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_err(ld_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_err(rd_err), .busy(busy)
  );

  iram_dp #(.DATA_W(16), .ADDR_W(9), .DEPTH(32), .CLEAR_ON_RESET(1'b0)) dutNoClear (
    .clk(clk), .rst(ncRst),
    .ld_valid(ncLdValid), .ld_ready(ncLdReady), .ld_addr(ncLdAddr), .ld_data(ncLdData),
    .ld_err(ncLdErr),
    .rd_en(ncRdEn), .rd_addr(ncRdAddr), .rd_data(ncRdData), .rd_valid(ncRdValid),
    .rd_err(ncRdErr), .busy(ncBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyLoad(input logic [8:0] addr, input logic [15:0] data);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic applyFetch(input string tag, input logic [8:0] addr,
                            input logic [15:0] expData, input logic expErr);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en   = 1'b0;
    checkOutput({tag, ".valid"}, 32'(rd_valid), 32'd1);
    checkOutput({tag, ".err"},   32'(rd_err),   32'(expErr));
    checkOutput({tag, ".data"},  32'(rd_data),  32'(expData));
  endtask

  task automatic countBusy(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int busyCycles;
    int validSeen;
    int errSeen;

    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rd_en = 1'b0; rd_addr = '0;
    ncRst = 1'b1; ncLdValid = 1'b0; ncLdAddr = '0; ncLdData = '0; ncRdEn = 1'b0; ncRdAddr = '0;

    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst.busy",    32'(busy),     32'd1);
    checkOutput("rst.ldReady", 32'(ld_ready), 32'd0);
    checkOutput("rst.rdValid", 32'(rd_valid), 32'd0);
    checkOutput("rst.rdErr",   32'(rd_err),   32'd0);
    checkOutput("rst.ldErr",   32'(ld_err),   32'd0);
    checkOutput("rst.rdData",  32'(rd_data),  32'd0);
    checkOutput("nc.rst.busy",    32'(ncBusy),    32'd0);
    checkOutput("nc.rst.ldReady", 32'(ncLdReady), 32'd1);

    rst   = 1'b0;
    ncRst = 1'b0;
    countBusy(busyCycles);
    $display("[TB] clear sweep");
    checkOutput("sweep.cycles",  32'(busyCycles), 32'd32);
    checkOutput("sweep.ldReady", 32'(ld_ready),   32'd1);
    for (int i = 0; i < 32; i++) begin
      rd_en   = 1'b1;
      rd_addr = 9'(i);
      tick();
      checkOutput($sformatf("zero[%0d].valid", i), 32'(rd_valid), 32'd1);
      checkOutput($sformatf("zero[%0d].data", i),  32'(rd_data),  32'd0);
    end
    rd_en = 1'b0;

    $display("[TB] load and back-to-back fetch");
    applyLoad(9'd2, 16'd1025);
    applyLoad(9'd5, 16'd3075);
    checkOutput("load.ldErr", 32'(ld_err), 32'd0);
    rd_en   = 1'b1;
    rd_addr = 9'd5;
    tick();
    checkOutput("b2b0.valid", 32'(rd_valid), 32'd1);
    checkOutput("b2b0.err",   32'(rd_err),   32'd0);
    checkOutput("b2b0.data",  32'(rd_data),  32'd3075);
    rd_addr = 9'd2;
    tick();
    rd_en = 1'b0;
    checkOutput("b2b1.valid", 32'(rd_valid), 32'd1);
    checkOutput("b2b1.err",   32'(rd_err),   32'd0);
    checkOutput("b2b1.data",  32'(rd_data),  32'd1025);
    tick();
    checkOutput("idle.valid", 32'(rd_valid), 32'd0);
    checkOutput("idle.hold",  32'(rd_data),  32'd1025);

    $display("[TB] out-of-range load and fetch");
    applyLoad(9'd40, 16'd7);
    checkOutput("oor.ldErr",     32'(ld_err), 32'd1);
    tick();
    checkOutput("oor.ldErrDrop", 32'(ld_err), 32'd0);
    applyFetch("alias8", 9'd8, 16'd0, 1'b0);
    applyFetch("oor40",  9'd40, 16'd0, 1'b1);
    applyFetch("oor256", 9'd258, 16'd0, 1'b1);
    applyFetch("keep5",  9'd5, 16'd3075, 1'b0);

    $display("[TB] same-cycle load and fetch");
    ld_valid = 1'b1; ld_addr = 9'd3; ld_data = 16'd2050;
    rd_en    = 1'b1; rd_addr = 9'd3;
    tick();
    ld_valid = 1'b0; rd_en = 1'b0;
    checkOutput("wf.valid", 32'(rd_valid), 32'd1);
    checkOutput("wf.data",  32'(rd_data),  32'd2050);
    ld_valid = 1'b1; ld_addr = 9'd6; ld_data = 16'd100;
    rd_en    = 1'b1; rd_addr = 9'd2;
    tick();
    ld_valid = 1'b0; rd_en = 1'b0;
    checkOutput("diff.data", 32'(rd_data), 32'd1025);
    applyFetch("diff6", 9'd6, 16'd100, 1'b0);

    $display("[TB] reset mid-sweep");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("mid.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    ld_valid = 1'b1; ld_addr = 9'd4; ld_data = 16'h1234;
    rd_en    = 1'b1; rd_addr = 9'd2;
    rst = 1'b0;
    busyCycles = 0;
    validSeen  = 0;
    errSeen    = 0;
    while (busy && busyCycles < 100) begin
      if (ld_ready) errSeen++;
      tick();
      busyCycles++;
      if (rd_valid) validSeen++;
      if (ld_err) errSeen++;
    end
    ld_valid = 1'b0; rd_en = 1'b0;
    checkOutput("resweep.cycles", 32'(busyCycles), 32'd32);
    checkOutput("resweep.rdValid", 32'(validSeen), 32'd0);
    checkOutput("resweep.ldSide",  32'(errSeen),   32'd0);
    applyFetch("resweep4", 9'd4, 16'd0, 1'b0);
    applyFetch("resweep2", 9'd2, 16'd0, 1'b0);

    $display("[TB] no-clear variant");
    ncRst = 1'b1;
    tick();
    ncRst = 1'b0;
    tick();
    checkOutput("nc.busy",    32'(ncBusy),    32'd0);
    checkOutput("nc.ldReady", 32'(ncLdReady), 32'd1);
    ncLdValid = 1'b1; ncLdAddr = 9'd1; ncLdData = 16'd77;
    tick();
    ncLdValid = 1'b0;
    ncRdEn = 1'b1; ncRdAddr = 9'd1;
    tick();
    ncRdEn = 1'b0;
    checkOutput("nc.valid", 32'(ncRdValid), 32'd1);
    checkOutput("nc.data",  32'(ncRdData),  32'd77);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
